// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM states and default sizing for the data memory responder
package mem_pkg;
  localparam int DEF_DEPTH_WORDS = 64;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: byte enables, store lane shift, load extraction/extension and fault detection
module mem_align
  import mem_pkg::*;
(
  input  logic        wr,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wshift,
  output logic [31:0] rdata,
  output logic        fault
);
  logic [31:0] s;
  always_comb begin
    fault = (funct3[1:0] == 2'b01 && a[0]) || (funct3[1:0] == 2'b10 && a != 2'b00) ||
            funct3 == 3'b011 || funct3[2:1] == 2'b11 || (wr && funct3[2]);
    be = (fault || !wr) ? 4'b0000 :
         funct3[1:0] == 2'b00 ? 4'b0001 << a :
         funct3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
    wshift = wdata << {a, 3'b000};
    s = rword >> {a, 3'b000};
    rdata = fault            ? 32'h0 :
            funct3 == F3_LB  ? {{24{s[7]}}, s[7:0]} :
            funct3 == F3_LBU ? {24'h0, s[7:0]} :
            funct3 == F3_LH  ? {{16{s[15]}}, s[15:0]} :
            funct3 == F3_LHU ? {16'h0, s[15:0]} : s;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array data memory with a fixed-latency IDLE/WAIT/RESP handshake
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, nxt;
  logic [3:0] cnt;
  logic op_wr;
  logic [AW+1:0] a_q;
  logic [2:0] f3_q;
  logic [31:0] wd_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0] be;
  logic [31:0] wshift, rdata;
  logic fault, req;
  assign req = mem_read || mem_write;
  always_comb begin
    nxt = state;
    if (state == IDLE && req) nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
    else if (state == WAIT && cnt <= 4'd1) nxt = RESP;
    else if (state == RESP) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  // a simultaneous read and write is taken as a store
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_wr <= mem_write;
      a_q <= addr[AW+1:0];
      f3_q <= funct3;
      wd_q <= write_data;
    end
  end
  always_ff @(posedge clk) begin
    if (state == RESP)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_q[AW+1:2]][8*i +: 8] <= wshift[8*i +: 8];
  end
  mem_align u_align (
    .wr(op_wr),
    .a(a_q[1:0]),
    .funct3(f3_q),
    .wdata(wd_q),
    .rword(mem[a_q[AW+1:2]]),
    .be(be),
    .wshift(wshift),
    .rdata(rdata),
    .fault(fault)
  );
  assign ready = state == RESP;
  assign busy = state != IDLE;
  assign error = ready && fault;
  assign read_data = (ready && !op_wr) ? rdata : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors against a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance sharing inputs
module tb_data_mem_responder;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic reset, mem_read, mem_write;
  logic [31:0] addr, write_data;
  logic [2:0] funct3;
  logic [31:0] rd0, rd1;
  logic rdy0, rdy1, bsy0, bsy1, err0, err1;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [2:0] f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .funct3(funct3), .write_data(write_data), .read_data(rd0), .ready(rdy0), .busy(bsy0), .error(err0)
  );
  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .funct3(funct3), .write_data(write_data), .read_data(rd1), .ready(rdy1), .busy(bsy1), .error(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input logic sel, input logic r, input logic w, input logic [31:0] a,
                     input logic [2:0] f, input logic [31:0] d,
                     output logic [31:0] rdat, output logic e, output int lat);
    rdat = 32'h0;
    e = 1'b0;
    lat = 0;
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; funct3 = f; write_data = d;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFC; funct3 = 3'b111; write_data = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      if (sel ? rdy1 : rdy0) begin
        lat = i;
        rdat = sel ? rd1 : rd0;
        e = sel ? err1 : err0;
        chk("busy_at_ready", 32'(sel ? bsy1 : bsy0), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("ready_one_cycle", 32'(sel ? rdy1 : rdy0), 32'd0);
    chk("error_one_cycle", 32'(sel ? err1 : err0), 32'd0);
    chk("busy_after_resp", 32'(sel ? bsy1 : bsy0), 32'd0);
    chk("rdata_when_idle", sel ? rd1 : rd0, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    int lat;
    int pulses;
    vq.push_back('{1'b0, 1'b1, 32'h10,  F3_SW,  32'hDEADBEEF, 32'h0,        1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LW,  32'h0,        32'hDEADBEEF, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h11,  F3_SB,  32'hFFFFFF55, 32'h0,        1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LW,  32'h0,        32'hDEAD55EF, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h13,  F3_LB,  32'h0,        32'hFFFFFFDE, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h13,  F3_LBU, 32'h0,        32'h000000DE, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h12,  F3_LH,  32'h0,        32'hFFFFDEAD, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h12,  F3_LHU, 32'h0,        32'h0000DEAD, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LB,  32'h0,        32'hFFFFFFEF, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LH,  32'h0,        32'h000055EF, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h12,  F3_LW,  32'h0,        32'h0,        1'b1});
    vq.push_back('{1'b0, 1'b1, 32'h11,  F3_SH,  32'h00001111, 32'h0,        1'b1});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LW,  32'h0,        32'hDEAD55EF, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  3'b011, 32'h0,        32'h0,        1'b1});
    vq.push_back('{1'b0, 1'b1, 32'h10,  3'b100, 32'h77777777, 32'h0,        1'b1});
    vq.push_back('{1'b1, 1'b0, 32'h11,  3'b111, 32'h0,        32'h0,        1'b1});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LW,  32'h0,        32'hDEAD55EF, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h12,  F3_SH,  32'h9999ABCD, 32'h0,        1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  F3_LW,  32'h0,        32'hABCD55EF, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h100, F3_SW,  32'h12345678, 32'h0,        1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h000, F3_LW,  32'h0,        32'h12345678, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h20,  F3_SW,  32'h11111111, 32'h0,        1'b0});
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; funct3 = 3'b0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bsy0), 32'd0);
    chk("reset_ready", 32'(rdy0), 32'd0);
    chk("reset_error", 32'(err0), 32'd0);
    chk("reset_rdata", rd0, 32'h0);
    reset = 1'b0;
    foreach (vq[i]) begin
      run(1'b0, vq[i].rd, vq[i].wr, vq[i].a, vq[i].f3, vq[i].wd, r, e, lat);
      chk($sformatf("rdata[%0d]", i), r, vq[i].exp_rd);
      chk($sformatf("error[%0d]", i), 32'(e), 32'(vq[i].exp_err));
      chk($sformatf("latency[%0d]", i), lat, 32'd3);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h20; funct3 = F3_SW; write_data = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    chk("abort_busy_in_wait", 32'(bsy0), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy_now", 32'(bsy0), 32'd0);
    chk("abort_ready_now", 32'(rdy0), 32'd0);
    chk("abort_rdata_now", rd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy0 || rdy1) pulses++;
    end
    chk("abort_no_ready", pulses, 32'd0);
    run(1'b0, 1'b1, 1'b0, 32'h20, F3_LW, 32'h0, r, e, lat);
    chk("abort_prior_contents", r, 32'h11111111);
    run(1'b1, 1'b1, 1'b1, 32'h8, F3_SW, 32'h1, r, e, lat);
    chk("w0_store_latency", lat, 32'd1);
    chk("w0_store_error", 32'(e), 32'd0);
    run(1'b1, 1'b1, 1'b0, 32'h8, F3_LW, 32'h0, r, e, lat);
    chk("w0_load_latency", lat, 32'd1);
    chk("w0_load_rdata", r, 32'h1);
    run(1'b0, 1'b1, 1'b0, 32'h8, F3_LW, 32'h0, r, e, lat);
    chk("both_high_is_store", r, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
